shreg_ctrl: RTL
===============

# shreg_ctrl

- Sequencing controller for the 4-bit universal shift register. It accepts one command at a time and drives the register's mode select, parallel data and serial input.
- Commands are parallel load, serial shift-in, serial shift-out and (optionally) rotate.
- It counts shift cycles, captures the final register contents and reports completion with a one-cycle pulse.
- It sits between a command source and one shift-register instance; the register itself stays unmodified and has no reset.

## Interface

Parameters: none. Register width is fixed at 4.

- clk  in  1  rising-edge clock, shared with the shift register.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  opcode:
  - 00 LOAD
  - 01 SHIFT_IN
  - 10 SHIFT_OUT
  - 11 ROTATE
- cmd_data  in  4  parallel word for LOAD.
- cmd_len  in  2  shift count minus 1; n = cmd_len+1, range 1..4.
- ser_in  in  1  serial data source for SHIFT_IN.
- ser_out  out  1  serial data for SHIFT_OUT; equals reg_A[3] while ser_out_valid=1.
- ser_out_valid  out  1  ser_out carries a bit this cycle.
- reg_s  out  2  mode select to the register:
  - 00 shift, A <= {A[2:0], inp}
  - 01 parallel load
  - 10 hold (11 also holds; the controller never drives 11)
- reg_I  out  4  parallel data to the register.
- reg_inp  out  1  serial input to the register.
- reg_A  in  4  register state.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  4  reg_A captured at the end of the last command.

## Operation

States: IDLE, EXEC, CAPTURE.

- IDLE:
  - cmd_ready=1, reg_s=10.
  - When cmd_valid is high, latch cmd_op, cmd_data into reg_I, and cnt=cmd_len, then go to EXEC.
- EXEC, LOAD: one cycle with reg_s=01, then go to CAPTURE.
- EXEC, SHIFT_IN:
  - Lasts n cycles with reg_s=00.
  - reg_inp=ser_in, a combinational pass-through; the register samples it at each edge.
- EXEC, SHIFT_OUT:
  - Lasts n cycles with reg_s=00 and reg_inp=0.
  - ser_out=reg_A[3] and ser_out_valid=1 each cycle, so the MSB goes out first.
- EXEC, ROTATE: lasts n cycles with reg_s=00 and reg_inp=reg_A[3].
- Counting in EXEC:
  - cnt decrements each cycle.
  - The controller leaves EXEC in the cycle where cnt==0.
  - cnt is 2 bits and never wraps below 0.
- CAPTURE:
  - One cycle with reg_s=10.
  - result <= reg_A at the end of the cycle, then go to IDLE.
  - done is registered so that it is high in the first IDLE cycle after CAPTURE.
- Outside EXEC: reg_s=10, reg_inp=0, ser_out=0, ser_out_valid=0.
- Commands offered while busy are ignored: no queueing and no error flag.
- Back-to-back: a command offered during the done cycle is accepted; done and cmd_ready coincide.
- Reset:
  - Values: state=IDLE, cnt=0, reg_I=0, result=0, done=0; busy=0, cmd_ready=1 from the next cycle.
  - Reset during EXEC or CAPTURE aborts the command. No done pulse is produced and result is not updated.
  - The register keeps whatever it shifted before the abort.
- Reset has priority over a simultaneous cmd_valid.

## Timing

- The accept edge is the end of cycle 0.
- LOAD: EXEC in cycle 1, CAPTURE in cycle 2; done=1 and result valid in cycle 3.
- Shift ops with n shifts: EXEC in cycles 1..n, CAPTURE in n+1, done in n+2.
- Maximum command rate: one per n+2 cycles.
- Register updates land on the edge ending each EXEC cycle.
- result changes only on the edge ending CAPTURE.
- All outputs except reg_inp and ser_out are registered or decoded from state. reg_inp and ser_out are combinational on ser_in and reg_A.

## Configuration

- Macro ROTATE_EN.
- Defined: opcode 11 performs ROTATE as above.
- Undefined:
  - Opcode 11 is a NOP. The controller goes IDLE→CAPTURE directly, with reg_s=10 throughout.
  - done arrives in cycle 2; result = the unchanged reg_A.
  - The reg_inp=reg_A[3] path is absent from the netlist.

## Test plan

The bench pairs the controller with the universal shift register.

- LOAD, cmd_data=1010:
  - reg_s=01 in cycle 1 only.
  - done=1 in cycle 3, result=1010.
- After LOAD 1010: SHIFT_IN, cmd_len=01, ser_in=1 then 1:
  - reg_s=00 for 2 cycles.
  - Register goes 0101, then 1011; done in cycle 4, result=1011.
- From 1011: SHIFT_OUT, cmd_len=11:
  - ser_out=1,0,1,1 with ser_out_valid high for 4 cycles.
  - done in cycle 6, result=0000.
- From 1001: ROTATE, cmd_len=00:
  - With ROTATE_EN: result=0011 in cycle 3.
  - Without ROTATE_EN: reg_s never 00, done in cycle 2, result=1001.
- SHIFT_IN, cmd_len=11, with rst=1 in the second EXEC cycle:
  - Next cycle busy=0, cmd_ready=1, result=0.
  - done stays 0 for 8 cycles.
- cmd_valid held high with LOAD 0110 throughout a SHIFT_IN cmd_len=00:
  - Not accepted while busy.
  - Accepted in the done cycle (cycle 3); reg_s=01 in cycle 4, result=0110 in cycle 6.

Source files
------------

// File: rtl/shreg_ctrl.sv
// Sequencing controller for a 4-bit universal shift register: load, shift-in,
// shift-out and (with macro ROTATE_EN defined) rotate, with a completion pulse.
module shreg_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [1:0] cmd_len,
  input  logic       ser_in,
  output logic       ser_out,
  output logic       ser_out_valid,
  output logic [1:0] reg_s,
  output logic [3:0] reg_I,
  output logic       reg_inp,
  input  logic [3:0] reg_A,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_EXEC    = 2'b01,
    S_CAPTURE = 2'b10
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SHIN  = 2'b01;
  localparam logic [1:0] OP_SHOUT = 2'b10;
  localparam logic [1:0] OP_ROT   = 2'b11;

  localparam logic [1:0] RS_SHIFT = 2'b00;
  localparam logic [1:0] RS_LOAD  = 2'b01;
  localparam logic [1:0] RS_HOLD  = 2'b10;

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] reg_i_q, reg_i_d;
  logic [3:0] result_q, result_d;
  logic       done_q, done_d;

  // Saturating decrement: the shift counter must never wrap below zero.
  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_LOAD;
      cnt_q    <= 2'd0;
      reg_i_q  <= 4'd0;
      result_q <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      reg_i_q  <= reg_i_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    reg_i_d       = reg_i_q;
    result_d      = result_q;
    done_d        = 1'b0;
    reg_s         = RS_HOLD;
    reg_inp       = 1'b0;
    ser_out       = 1'b0;
    ser_out_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          reg_i_d = cmd_data;
          cnt_d   = cmd_len;
`ifdef ROTATE_EN
          state_d = S_EXEC;
`else
          // Without rotate support opcode 11 is a NOP that only captures.
          state_d = (cmd_op == OP_ROT) ? S_CAPTURE : S_EXEC;
`endif
        end
      end

      S_EXEC: begin
        cnt_d = cnt_dec(cnt_q);
        unique case (op_q)
          OP_LOAD: begin
            reg_s   = RS_LOAD;
            cnt_d   = 2'd0;
            state_d = S_CAPTURE;
          end
          OP_SHIN: begin
            reg_s   = RS_SHIFT;
            reg_inp = ser_in;
            if (cnt_q == 2'd0) state_d = S_CAPTURE;
          end
          OP_SHOUT: begin
            reg_s         = RS_SHIFT;
            ser_out       = reg_A[3];
            ser_out_valid = 1'b1;
            if (cnt_q == 2'd0) state_d = S_CAPTURE;
          end
          OP_ROT: begin
`ifdef ROTATE_EN
            reg_s   = RS_SHIFT;
            reg_inp = reg_A[3];
            if (cnt_q == 2'd0) state_d = S_CAPTURE;
`else
            state_d = S_CAPTURE;
`endif
          end
          default: state_d = S_CAPTURE;
        endcase
      end

      S_CAPTURE: begin
        result_d = reg_A;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign reg_I     = reg_i_q;
  assign result    = result_q;
  assign done      = done_q;

endmodule
